biu_bus_controller: RTL
=======================

// Module: biu_bus_controller
// PURPOSE
//  Bus interface unit sequencer for the 8088 datapath.
//  - Owns the 8-bit external bus and runs 4-state bus cycles (T1-T4).
//  - Arbitrates between execution-unit (EU) memory requests and instruction prefetch.
//  - Fills a byte prefetch queue, forms 20-bit physical addresses as {seg,4'h0}+offset,
//    and splits 16-bit EU transfers into two byte cycles.
// PARAMETERS
//  QUEUE_DEPTH  4   prefetch queue depth in bytes (power of 2, >=2)
//  ADDR_W       20  physical address width
// PORTS
//  clk         in   1   system clock, rising edge
//  reset       in   1   asynchronous, active-high reset
//  cs_base     in   16  code segment for prefetch
//  ip_start    in   16  new fetch offset, used with ip_load
//  ip_load     in   1   flush queue, set fetch offset := ip_start, enable prefetch
//  eu_req      in   1   EU memory request; hold until eu_ack
//  eu_wr       in   1   0=read (leer), 1=write (escribir)
//  eu_byte     in   1   1=single byte, 0=16-bit word (low byte first)
//  eu_seg      in   16  EU segment value
//  eu_offset   in   16  EU offset
//  eu_wdata    in   16  EU write data
//  eu_ack      out  1   1-cycle pulse: EU transfer complete
//  eu_rdata    out  16  read data; valid with eu_ack, held until next ack
//  q_byte      out  8   queue head byte
//  q_valid     out  1   queue non-empty
//  q_pop       in   1   consume head byte
//  Direction   out  20  bus address
//  RD_WR       out  1   0=read, 1=write
//  EN          out  1   address strobe, high in T1 only
//  Data_out    out  8   write data
//  Data_oe     out  1   drive enable for Data_out (T2-T4 of writes)
//  Data_in     in   8   read data, sampled at end of T3
//  ready       in   1   only with WAIT_STATES_EN
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; queue empty; fetch offset 0; prefetch disabled.
//  FSM states:
//  - IDLE -> T1 when a request is pending; T1 -> T2 -> T3 -> T4.
//  - T4 re-arbitrates: pending request -> T1, otherwise -> IDLE.
//  Arbitration in IDLE/T4: EU request > prefetch (enabled and queue not full) > idle.
//  Outputs per state:
//  - Direction valid T1-T4. EN=1 in T1. RD_WR valid T1-T4.
//  - Data_out/Data_oe driven T2-T4 on writes.
//  Read timing: Data_in captured on the rising edge ending T3.
//  EU byte transfer: eu_req sampled in cycle k (IDLE) -> T1 at k+1, eu_ack at k+4 (T4).
//  EU word transfer:
//  - second cycle uses offset+1 (mod 2^16); address is recomputed, seg unchanged.
//  - low byte moves first; eu_ack in T4 of the second cycle (k+8); no prefetch between.
//  - byte read: eu_rdata = {8'h00, byte}.
//  Address arithmetic: ({seg,4'h0} + offset) mod 2^20, so wrap past 20'hFFFFF goes to 0.
//  Prefetch:
//  - address {cs_base,4'h0}+fetch_off; byte pushed at end of T3.
//  - fetch_off increments mod 2^16 per fetched byte.
//  Queue:
//  - push and pop in the same cycle leave the count unchanged.
//  - pop when empty is ignored; no prefetch is started while full.
//  ip_load (highest priority):
//  - empties the queue in the same edge and overrides a simultaneous pop.
//  - an in-flight prefetch cycle completes on the bus; its byte is discarded.
//  - an in-flight EU cycle is unaffected.
//  eu_req deasserted mid-transfer: the transfer still completes; eu_ack still pulses.
//  Reset mid-cycle: immediate return to IDLE; the partial transfer is abandoned; no ack.
// CONFIGURATION
//  WAIT_STATES_EN:
//  - defined: adds the ready input. At end of T3, ready=0 inserts Tw states (T3 outputs
//    held, Data_in not sampled) until ready=1. Sampling happens in the cycle ready=1.
//  - undefined: no ready port; every bus cycle is exactly 4 clocks.
// TESTING
//  1. ip_load=1, cs_base=16'h1000, ip_start=16'h0010 -> prefetches at 20'h10010..10013;
//     queue fills to 4; no 5th cycle until q_pop.
//  2. EU byte read, seg=16'h2000, off=16'h0005, Data_in=8'hA5 -> Direction=20'h20005,
//     EN in T1, eu_ack 4 clocks after issue, eu_rdata=16'h00A5.
//  3. EU word write, seg=16'hFFFF, off=16'h000F, wdata=16'hBEEF -> cycle 1 at 20'hFFFFF
//     with 8'hEF, cycle 2 at 20'h00000 with 8'hBE; single eu_ack.
//  4. ip_load during a prefetch T2 -> queue empty next cycle, fetched byte discarded,
//     next fetch at {cs_base,4'h0}+new ip_start.
//  5. eu_req and a prefetch both pending in IDLE -> EU cycle first; pop+push same cycle
//     keeps count.
//  6. WAIT_STATES_EN, ready low 3 cycles in T3 -> 3 Tw states, eu_ack at k+7, correct data.

Source files
------------

// File: rtl/biu_bus_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : biu_bus_controller                                           |
// | Description : 8088 bus interface unit: T1-T4 bus sequencer, EU/prefetch    |
// |               arbitration, byte prefetch queue, 20-bit address formation.  |
// |               Optional macro WAIT_STATES_EN adds the ready input / Tw.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module biu_bus_controller #(
  parameter int QUEUE_DEPTH = 4,
  parameter int ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       cs_base,
  input  logic [15:0]       ip_start,
  input  logic              ip_load,
  input  logic              eu_req,
  input  logic              eu_wr,
  input  logic              eu_byte,
  input  logic [15:0]       eu_seg,
  input  logic [15:0]       eu_offset,
  input  logic [15:0]       eu_wdata,
  output logic              eu_ack,
  output logic [15:0]       eu_rdata,
  output logic [7:0]        q_byte,
  output logic              q_valid,
  input  logic              q_pop,
  output logic [ADDR_W-1:0] Direction,
  output logic              RD_WR,
  output logic              EN,
  output logic [7:0]        Data_out,
  output logic              Data_oe,
  input  logic [7:0]        Data_in
`ifdef WAIT_STATES_EN
  ,
  input  logic              ready
`endif
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(QUEUE_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_TW   = 3'd4,
    S_T4   = 3'd5
  } state_t;

  state_t                        state_q, state_d;
  logic                          cyc_eu_q, cyc_eu_d;
  logic                          cyc_wr_q, cyc_wr_d;
  logic                          eu_word_q, eu_word_d;
  logic                          word_lo_q, word_lo_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [7:0]                    wbyte_q, wbyte_d;
  logic [7:0]                    wdata_hi_q, wdata_hi_d;
  logic [15:0]                   seg_q, seg_d;
  logic [15:0]                   off_q, off_d;
  logic [7:0]                    lo_byte_q, lo_byte_d;
  logic [15:0]                   eu_rdata_q, eu_rdata_d;
  logic [15:0]                   fetch_off_q, fetch_off_d;
  logic                          pf_en_q, pf_en_d;
  logic                          discard_q, discard_d;
  logic [QUEUE_DEPTH-1:0][7:0]   mem_q, mem_d;
  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]              count_q, count_d;

  logic w_sample;
  logic w_wait;
  logic w_push;
  logic w_pop;
  logic w_arb;
  logic w_in_data_phase;

`ifdef WAIT_STATES_EN
  assign w_sample = (state_q == S_T3 || state_q == S_TW) && ready;
  assign w_wait   = (state_q == S_T3 || state_q == S_TW) && !ready;
`else
  assign w_sample = (state_q == S_T3);
  assign w_wait   = 1'b0;
`endif

  function automatic logic [ADDR_W-1:0] phys_addr(input logic [15:0] seg, input logic [15:0] off);
    return ADDR_W'({seg, 4'h0}) + ADDR_W'(off);
  endfunction

  always_comb begin
    state_d     = state_q;
    cyc_eu_d    = cyc_eu_q;
    cyc_wr_d    = cyc_wr_q;
    eu_word_d   = eu_word_q;
    word_lo_d   = word_lo_q;
    addr_d      = addr_q;
    wbyte_d     = wbyte_q;
    wdata_hi_d  = wdata_hi_q;
    seg_d       = seg_q;
    off_d       = off_q;
    lo_byte_d   = lo_byte_q;
    eu_rdata_d  = eu_rdata_q;
    fetch_off_d = fetch_off_q;
    pf_en_d     = pf_en_q;
    discard_d   = discard_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    w_push      = 1'b0;
    w_arb       = 1'b0;

    case (state_q)
      S_IDLE:     w_arb   = 1'b1;
      S_T1:       state_d = S_T2;
      S_T2:       state_d = S_T3;
      S_T3, S_TW: state_d = w_wait ? S_TW : S_T4;
      S_T4:       w_arb   = 1'b1;
      default:    state_d = S_IDLE;
    endcase

    if (w_arb) begin
      state_d = S_IDLE;
      if (state_q == S_T4 && cyc_eu_q && word_lo_q) begin
        // High byte of a word transfer: same segment, offset+1 wrapping in 16 bits
        state_d   = S_T1;
        word_lo_d = 1'b0;
        addr_d    = phys_addr(seg_q, off_q + 16'd1);
        wbyte_d   = wdata_hi_q;
      end else if (eu_req && !(state_q == S_T4 && cyc_eu_q)) begin
        // The EU still holds eu_req during its own ack cycle, so it is not re-accepted then
        state_d    = S_T1;
        cyc_eu_d   = 1'b1;
        cyc_wr_d   = eu_wr;
        eu_word_d  = !eu_byte;
        word_lo_d  = !eu_byte;
        addr_d     = phys_addr(eu_seg, eu_offset);
        wbyte_d    = eu_wdata[7:0];
        wdata_hi_d = eu_wdata[15:8];
        seg_d      = eu_seg;
        off_d      = eu_offset;
        discard_d  = 1'b0;
      end else if (pf_en_q && count_q < C_FULL && !ip_load) begin
        state_d   = S_T1;
        cyc_eu_d  = 1'b0;
        cyc_wr_d  = 1'b0;
        eu_word_d = 1'b0;
        word_lo_d = 1'b0;
        addr_d    = phys_addr(cs_base, fetch_off_q);
        discard_d = 1'b0;
      end
    end

    if (w_sample && !cyc_wr_q) begin
      if (cyc_eu_q) begin
        if (word_lo_q)      lo_byte_d  = Data_in;
        else if (eu_word_q) eu_rdata_d = {Data_in, lo_byte_q};
        else                eu_rdata_d = {8'h00, Data_in};
      end else if (!discard_q && !ip_load) begin
        w_push = 1'b1;
      end
    end

    w_pop = q_pop && (count_q != '0) && !ip_load;

    if (ip_load) begin
      count_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      fetch_off_d = ip_start;
      pf_en_d     = 1'b1;
      if (!cyc_eu_q && state_q != S_IDLE && state_q != S_T4)
        discard_d = 1'b1;
    end else begin
      if (w_push) begin
        mem_d[wr_ptr_q] = Data_in;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        fetch_off_d     = fetch_off_q + 16'd1;
      end
      if (w_pop)
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (w_push && !w_pop)
        count_d = count_q + CNT_W'(1);
      else if (w_pop && !w_push)
        count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cyc_eu_q    <= 1'b0;
      cyc_wr_q    <= 1'b0;
      eu_word_q   <= 1'b0;
      word_lo_q   <= 1'b0;
      addr_q      <= '0;
      wbyte_q     <= '0;
      wdata_hi_q  <= '0;
      seg_q       <= '0;
      off_q       <= '0;
      lo_byte_q   <= '0;
      eu_rdata_q  <= '0;
      fetch_off_q <= '0;
      pf_en_q     <= 1'b0;
      discard_q   <= 1'b0;
      mem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cyc_eu_q    <= cyc_eu_d;
      cyc_wr_q    <= cyc_wr_d;
      eu_word_q   <= eu_word_d;
      word_lo_q   <= word_lo_d;
      addr_q      <= addr_d;
      wbyte_q     <= wbyte_d;
      wdata_hi_q  <= wdata_hi_d;
      seg_q       <= seg_d;
      off_q       <= off_d;
      lo_byte_q   <= lo_byte_d;
      eu_rdata_q  <= eu_rdata_d;
      fetch_off_q <= fetch_off_d;
      pf_en_q     <= pf_en_d;
      discard_q   <= discard_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign w_in_data_phase = (state_q == S_T2) || (state_q == S_T3) ||
                           (state_q == S_TW) || (state_q == S_T4);

  assign Direction = (state_q != S_IDLE) ? addr_q : '0;
  assign RD_WR     = (state_q != S_IDLE) && cyc_wr_q;
  assign EN        = (state_q == S_T1);
  assign Data_oe   = cyc_wr_q && w_in_data_phase;
  assign Data_out  = Data_oe ? wbyte_q : 8'h00;
  assign eu_ack    = (state_q == S_T4) && cyc_eu_q && !word_lo_q;
  assign eu_rdata  = eu_rdata_q;
  assign q_valid   = (count_q != '0);
  assign q_byte    = q_valid ? mem_q[rd_ptr_q] : 8'h00;

endmodule
`default_nettype wire
